// File: rtl/trace_arbiter.sv
// Round-robin merge of pass-through (src0) and retired (src1) trace elements
// into a small FIFO that drains to the trace sink over valid/ready.
package trace_arbiter_pkg;
   typedef struct packed {
      logic [31:0] instruction;
      logic [31:0] pc;
      logic [31:0] ex_data;
      logic        pass_through;
   } trace_output;
endpackage

module trace_arbiter
   import trace_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              src0_valid,
   input  trace_output       src0_data,
   output logic              src0_ack,
   input  logic              src1_valid,
   input  trace_output       src1_data,
   output logic              src1_ack,
   output logic              out_valid,
   output trace_output       out_data,
   input  logic              out_ready,
   input  logic              flush,
   output logic [LVL_W-1:0]  fifo_level
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   typedef enum logic {
      SRC0 = 1'b0,
      SRC1 = 1'b1
   } src_e;

   trace_output      mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [LVL_W-1:0] count_q, count_d;
   src_e             last_grant_q, last_grant_d;

   logic             pop;
   logic             space;
   logic             grant0;
   logic             grant1;
   logic             accept;
   logic             push;
   trace_output      push_data;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      pop       = (count_q != '0) & out_ready;
      space     = (count_q < LVL_W'(FIFO_DEPTH)) | pop;
      grant0    = 1'b0;
      grant1    = 1'b0;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q;
      last_grant_d = last_grant_q;

      if (src0_valid && src1_valid) begin
         if (last_grant_q == SRC1) grant0 = 1'b1;
         else                      grant1 = 1'b1;
      end else begin
         grant0 = src0_valid;
         grant1 = src1_valid;
      end

      // Acks are held low while reset is asserted, not just after the first edge.
      accept    = space & ~flush & ~rst;
      src0_ack  = grant0 & accept;
      src1_ack  = grant1 & accept;
      push      = src0_ack | src1_ack;
      push_data = src1_ack ? src1_data : src0_data;

      if (flush) begin
         rd_ptr_d     = '0;
         wr_ptr_d     = '0;
         count_d      = '0;
         last_grant_d = SRC1;
      end else begin
         if (push) begin
            wr_ptr_d     = wr_ptr_q + PTR_W'(1);
            last_grant_d = src1_ack ? SRC1 : SRC0;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d = count_q + LVL_W'(push) - LVL_W'(pop);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
         count_q      <= '0;
         last_grant_q <= SRC1;
      end else begin
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         count_q      <= count_d;
         last_grant_q <= last_grant_d;
      end
   end

   // NOTE: storage has no reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_data;
   end

   assign out_valid  = (count_q != '0);
   assign out_data   = mem_q[rd_ptr_q];
   assign fifo_level = count_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: arbitration order, full/empty behaviour,
// pointer wrap, flush and asynchronous reset.
module tb_trace_arbiter;
   import trace_arbiter_pkg::*;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              src0_valid;
   trace_output       src0_data;
   logic              src0_ack;
   logic              src1_valid;
   trace_output       src1_data;
   logic              src1_ack;
   logic              out_valid;
   trace_output       out_data;
   logic              out_ready;
   logic              flush;
   logic [LVL_W-1:0]  fifo_level;

   int n_checks = 0;
   int n_errors = 0;

   trace_arbiter #(.FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .src0_valid (src0_valid),
      .src0_data  (src0_data),
      .src0_ack   (src0_ack),
      .src1_valid (src1_valid),
      .src1_data  (src1_data),
      .src1_ack   (src1_ack),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .flush      (flush),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic trace_output mk(input logic [31:0] instr, input logic pt);
      trace_output t;
      t.instruction  = instr;
      t.pc           = {instr[15:0], 16'h0000};
      t.ex_data      = ~instr;
      t.pass_through = pt;
      return t;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      trace_output exp_e;
      int          j;

      rst        = 1'b1;
      src0_valid = 1'b0;
      src0_data  = '0;
      src1_valid = 1'b1;
      src1_data  = mk(32'h0000_0013, 1'b0);
      out_ready  = 1'b1;
      flush      = 1'b0;

      // Reset state and single element through src1
      tick();
      tick();
      check("rst_valid", 128'(out_valid), 128'(0));
      check("rst_level", 128'(fifo_level), 128'(0));
      check("rst_ack1", 128'(src1_ack), 128'(0));
      rst = 1'b0;
      settle();
      check("t1_ack1", 128'(src1_ack), 128'(1));
      check("t1_ack0", 128'(src0_ack), 128'(0));
      tick();
      src1_valid = 1'b0;
      settle();
      check("t1_valid", 128'(out_valid), 128'(1));
      check("t1_data", 128'(out_data), 128'(mk(32'h0000_0013, 1'b0)));
      check("t1_lvl1", 128'(fifo_level), 128'(1));
      tick();
      check("t1_lvl0", 128'(fifo_level), 128'(0));
      check("t1_empty", 128'(out_valid), 128'(0));

      // Contention: strict alternation starting with src0
      src0_valid = 1'b1;
      src1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         src0_data = mk(32'hA000_0000 + 32'((i + 1) / 2), 1'b1);
         src1_data = mk(32'hB000_0000 + 32'(i / 2), 1'b0);
         settle();
         check($sformatf("t2_ack0_%0d", i), 128'(src0_ack), 128'(i % 2 == 0));
         check($sformatf("t2_ack1_%0d", i), 128'(src1_ack), 128'(i % 2 == 1));
         if (i > 0) begin
            j = i - 1;
            exp_e = (j % 2 == 0) ? mk(32'hA000_0000 + 32'(j / 2), 1'b1)
                                 : mk(32'hB000_0000 + 32'(j / 2), 1'b0);
            check($sformatf("t2_out_%0d", i), 128'(out_data), 128'(exp_e));
            check($sformatf("t2_lvl_%0d", i), 128'(fifo_level), 128'(1));
         end
         tick();
      end
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      settle();
      check("t2_out_last", 128'(out_data), 128'(mk(32'hB000_0002, 1'b0)));
      tick();
      check("t2_drained", 128'(fifo_level), 128'(0));

      // Fill to full with sink stalled, then push into full FIFO alongside a pop
      out_ready  = 1'b0;
      src0_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src0_data = mk(32'hC000_0000 + 32'(i), 1'b1);
         settle();
         check($sformatf("t3_ack_%0d", i), 128'(src0_ack), 128'(1));
         tick();
      end
      src0_data = mk(32'hC000_0004, 1'b1);
      settle();
      check("t3_full_lvl", 128'(fifo_level), 128'(4));
      check("t3_full_noack", 128'(src0_ack), 128'(0));
      check("t3_head", 128'(out_data), 128'(mk(32'hC000_0000, 1'b1)));
      tick();
      check("t3_hold_lvl", 128'(fifo_level), 128'(4));
      check("t3_hold_noack", 128'(src0_ack), 128'(0));
      check("t3_hold_head", 128'(out_data), 128'(mk(32'hC000_0000, 1'b1)));
      out_ready = 1'b1;
      settle();
      check("t3_pushpop_ack", 128'(src0_ack), 128'(1));
      tick();
      src0_valid = 1'b0;
      settle();
      check("t3_after_lvl", 128'(fifo_level), 128'(4));
      check("t3_after_head", 128'(out_data), 128'(mk(32'hC000_0001, 1'b1)));
      for (int k = 2; k <= 4; k++) begin
         tick();
         check($sformatf("t3_drain_%0d", k), 128'(out_data), 128'(mk(32'hC000_0000 + 32'(k), 1'b1)));
      end
      tick();
      check("t3_empty", 128'(fifo_level), 128'(0));

      // Sustained push+pop across several pointer wraps
      src1_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         src1_data = mk(32'hD000_0000 + 32'(i), 1'b0);
         settle();
         check($sformatf("t4_ack_%0d", i), 128'(src1_ack), 128'(1));
         if (i > 0)
            check($sformatf("t4_out_%0d", i), 128'(out_data), 128'(mk(32'hD000_0000 + 32'(i - 1), 1'b0)));
         tick();
      end
      src1_valid = 1'b0;
      settle();
      check("t4_out_last", 128'(out_data), 128'(mk(32'hD000_0009, 1'b0)));
      check("t4_lvl", 128'(fifo_level), 128'(1));
      tick();
      check("t4_empty", 128'(fifo_level), 128'(0));

      // Flush with three entries held and src1 waiting
      out_ready  = 1'b0;
      src0_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         src0_data = mk(32'hE000_0000 + 32'(i), 1'b1);
         tick();
      end
      src0_valid = 1'b0;
      settle();
      check("t5_lvl3", 128'(fifo_level), 128'(3));
      src1_valid = 1'b1;
      src1_data  = mk(32'hF000_0000, 1'b0);
      flush      = 1'b1;
      out_ready  = 1'b1;
      settle();
      check("t5_flush_ack1", 128'(src1_ack), 128'(0));
      check("t5_flush_ack0", 128'(src0_ack), 128'(0));
      tick();
      flush = 1'b0;
      settle();
      check("t5_lvl0", 128'(fifo_level), 128'(0));
      check("t5_valid0", 128'(out_valid), 128'(0));
      check("t5_ack_after", 128'(src1_ack), 128'(1));
      tick();
      src1_valid = 1'b0;
      check("t5_data", 128'(out_data), 128'(mk(32'hF000_0000, 1'b0)));
      check("t5_lvl1", 128'(fifo_level), 128'(1));
      tick();
      check("t5_empty", 128'(fifo_level), 128'(0));

      // Asynchronous reset mid-cycle with two entries held
      out_ready  = 1'b0;
      src0_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         src0_data = mk(32'h1000_0000 + 32'(i), 1'b1);
         tick();
      end
      src0_valid = 1'b0;
      settle();
      check("t6_lvl2", 128'(fifo_level), 128'(2));
      #1;
      rst        = 1'b1;
      src0_valid = 1'b1;
      src0_data  = mk(32'h2000_0000, 1'b1);
      src1_valid = 1'b1;
      src1_data  = mk(32'h3000_0000, 1'b0);
      #1;
      check("t6_rst_valid", 128'(out_valid), 128'(0));
      check("t6_rst_lvl", 128'(fifo_level), 128'(0));
      check("t6_rst_acks", 128'({src0_ack, src1_ack}), 128'(0));
      tick();
      check("t6_rst_hold_acks", 128'({src0_ack, src1_ack}), 128'(0));
      @(negedge clk);
      rst = 1'b0;
      settle();
      check("t6_first_ack0", 128'(src0_ack), 128'(1));
      check("t6_first_ack1", 128'(src1_ack), 128'(0));
      tick();
      src0_valid = 1'b0;
      src1_valid = 1'b0;
      check("t6_out", 128'(out_data), 128'(mk(32'h2000_0000, 1'b1)));
      check("t6_lvl", 128'(fifo_level), 128'(1));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/trace_arbiter.md
# trace_arbiter

Merges completed trace elements from two trace-pipeline sources into one ordered output stream. Source 0 carries pass-through elements (jumps, which exit early from the decode tracker). Source 1 carries fully retired elements from the write-back tracker. A round-robin arbiter grants at most one source per cycle into a small FIFO, which drains to the trace sink over a valid/ready handshake. The block sits between the tracker chain and the trace output logic.

## Interface
- FIFO_DEPTH, 4, number of trace_output entries buffered; power of two, ≥ 2
- LVL_W, $clog2(FIFO_DEPTH+1), width of fill-level output
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, asynchronous, active-high
- src0_valid  in  1  pass-through element offered; held until acked
- src0_data  in  trace_output  pass-through element; stable while src0_valid
- src0_ack  out  1  high in the cycle src0_data is written into the FIFO
- src1_valid  in  1  retired element offered; held until acked
- src1_data  in  trace_output  retired element; stable while src1_valid
- src1_ack  out  1  high in the cycle src1_data is written into the FIFO
- out_valid  out  1  FIFO non-empty
- out_data  out  trace_output  head-of-FIFO element
- out_ready  in  1  sink accepts out_data when high together with out_valid
- flush  in  1  synchronous clear of FIFO contents and arbiter history
- fifo_level  out  LVL_W  number of occupied entries

## Operation
- Storage: circular buffer of FIFO_DEPTH entries, plus rd_ptr, wr_ptr, and count (0..FIFO_DEPTH).
- pop = out_valid & out_ready.
- space = (count < FIFO_DEPTH) | pop. A push into a full FIFO is legal in the same cycle as a pop.
- Arbitration, combinational, evaluated every cycle:
  - Only src0 valid → grant src0.
  - Only src1 valid → grant src1.
  - Both valid → grant the source NOT granted last (last_grant register).
  - No grant when space = 0 or flush = 1.
- srcN_ack = grantN & space & ~flush. At most one ack per cycle.
- On an accepted grant:
  - mem[wr_ptr] ← srcN_data.
  - wr_ptr advances, wrapping from FIFO_DEPTH-1 to 0.
  - last_grant ← N.
- On pop: rd_ptr advances, with the same wrap rule.
- count ← count + push − pop. A simultaneous push and pop leaves count unchanged.
- out_valid = (count ≠ 0). out_data = mem[rd_ptr]. fifo_level = count.
- flush:
  - Next edge: rd_ptr, wr_ptr and count go to 0, and last_grant goes to 1.
  - No ack is issued and a pop in that cycle has no effect.
  - Sources keep valid asserted and are served after flush drops.
- Ordering within a source is preserved. Elements leave in acceptance order.
- Element contents are passed through unmodified. Fields such as pass_through and ex_data are never altered.
- Reset (asynchronous, any time, including mid-transfer): rd_ptr = wr_ptr = count = 0, last_grant = 1, mem contents don't-care.
- Output values during and after reset: out_valid = 0, fifo_level = 0, src0_ack = src1_ack = 0. Any element held in the FIFO is discarded.
- After reset deasserts, the first contested grant goes to src0.

## Timing
- src*_ack is combinational from valid, count, out_ready and flush. The source samples it at the same rising edge as the write. Next cycle it either drops valid or presents its next element.
- Latency: element accepted at edge N into an empty FIFO → out_valid = 1 with that element after edge N. It is poppable at edge N+1.
- Throughput: one push and one pop per cycle sustained.
- Contention with both sources continuously valid gives strict alternation, one ack per cycle.
- Full (count = FIFO_DEPTH) with out_ready = 0: no acks, sources stall, count holds.
- Empty with out_ready = 1: no pop, pointers hold.
- out_data must remain stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset, then src1_valid with instruction 0x00000013, out_ready = 1 → src1_ack in cycle 1, out_valid next cycle carrying 0x00000013, fifo_level 1 then 0.
- Both sources valid continuously with distinct instructions A0, A1… and B0, B1…, out_ready = 1 → acks alternate src0, src1, src0…; output order A0, B0, A1, B1.
- out_ready = 0 with src0 streaming 5 elements, FIFO_DEPTH = 4 → 4 acks, fifo_level = 4, 5th held. Raise out_ready → 5th acked in the same cycle as the first pop, fifo_level stays 4.
- Push and pop every cycle across 10 elements → pointers wrap cleanly, output order matches input, and out_data is correct at each wrap.
- fifo_level = 3, assert flush for one cycle while src1_valid = 1 → no ack, fifo_level = 0 next cycle; src1 acked in the cycle after flush drops.
- Assert rst asynchronously mid-cycle with fifo_level = 2 → out_valid and fifo_level drop to 0 immediately, no acks. After release, a contested first grant goes to src0.
